// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32 subset core: fetch, decode, execute,
// memory and write-back phases with memory-wait timeout, trap halt and instret.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic [5:0]       alu_op,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd5;

  localparam logic [5:0] OP_NONE = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SLL  = 6'd3;
  localparam logic [5:0] OP_JAL  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd5;
  localparam logic [5:0] OP_AND  = 6'd6;
  localparam logic [5:0] OP_OR   = 6'd7;
  localparam logic [5:0] OP_XOR  = 6'd8;
  localparam logic [5:0] OP_BLT  = 6'd9;
  localparam logic [5:0] OP_BEQ  = 6'd10;
  localparam logic [5:0] OP_SRL  = 6'd11;
  localparam logic [5:0] OP_LW   = 6'd12;
  localparam logic [5:0] OP_SW   = 6'd13;

  localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_FETCH   = 2'd2;
  localparam logic [1:0] CAUSE_MEM     = 2'd3;

  function automatic logic [5:0] decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
    logic [5:0] d;
    d = OP_NONE;
    case (op)
      7'b0110011: begin
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  d = OP_ADD;
            3'b001:  d = OP_SLL;
            3'b111:  d = OP_AND;
            3'b110:  d = OP_OR;
            3'b100:  d = OP_XOR;
            3'b101:  d = OP_SRL;
            default: d = OP_NONE;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          d = OP_SUB;
        end
      end
      7'b1101111: d = OP_JAL;
      7'b0010011: if (f3 == 3'b000) d = OP_ADDI;
      7'b1100011: begin
        case (f3)
          3'b100:  d = OP_BLT;
          3'b000:  d = OP_BEQ;
          default: d = OP_NONE;
        endcase
      end
      7'b0000011: if (f3 == 3'b010) d = OP_LW;
      7'b0100011: if (f3 == 3'b010) d = OP_SW;
      default:    d = OP_NONE;
    endcase
    return d;
  endfunction

  logic [2:0] next_state;
  logic [1:0] next_wb_sel;
  logic [1:0] next_cause;
  logic       retire;
  logic [5:0] dec_op;
  logic [7:0] wait_cnt;
  logic [8:0] wait_inc;
  logic       timed_out;

  assign dec_op    = decode(opcode, funct3, funct7);
  assign wait_inc  = {1'b0, wait_cnt} + 9'd1;
  assign timed_out = mem_req && !mem_ready && (wait_inc >= TIMEOUT);
  assign halted    = (state == S_TRAP);

  // Next-state and Mealy strobes; memory handshakes only count while mem_req is up.
  always_comb begin
    next_state  = state;
    next_wb_sel = wb_sel;
    next_cause  = trap_cause;
    retire      = 1'b0;
    mem_we      = 1'b0;
    mem_sel     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    case (state)
      S_FETCH: begin
        if (mem_req && mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = CAUSE_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_op == OP_NONE) begin
          next_state = S_TRAP;
          next_cause = CAUSE_ILLEGAL;
        end else begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        case (alu_op)
          OP_ADD, OP_SUB, OP_SLL, OP_AND, OP_OR, OP_XOR, OP_SRL, OP_ADDI: begin
            next_state  = S_WB;
            next_wb_sel = 2'd0;
          end
          OP_LW, OP_SW: next_state = S_MEM;
          OP_BEQ: begin
            pc_write   = alu_zero;
            pc_src     = 1'b1;
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          OP_BLT: begin
            pc_write   = alu_lt;
            pc_src     = 1'b1;
            next_state = S_FETCH;
            retire     = 1'b1;
          end
          // Link source is chosen here so WB writes old_pc+4, not the new PC.
          OP_JAL: begin
            pc_write    = 1'b1;
            pc_src      = 1'b1;
            next_state  = S_WB;
            next_wb_sel = 2'd2;
          end
          default: begin
            next_state = S_TRAP;
            next_cause = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_sel = 1'b1;
        mem_we  = mem_req && (alu_op == OP_SW);
        if (mem_req && mem_ready) begin
          if (alu_op == OP_SW) begin
            next_state = S_FETCH;
            retire     = 1'b1;
          end else begin
            next_state  = S_WB;
            next_wb_sel = 2'd1;
          end
        end else if (timed_out) begin
          next_state = S_TRAP;
          next_cause = CAUSE_MEM;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_TRAP: next_state = S_TRAP;
      default: begin
        next_state = S_TRAP;
        next_cause = CAUSE_ILLEGAL;
      end
    endcase
  end

  // mem_req is registered from the next state so it is low in the cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      alu_op     <= OP_NONE;
      wb_sel     <= 2'd0;
      trap_cause <= 2'd0;
      instret    <= '0;
      wait_cnt   <= 8'd0;
      mem_req    <= 1'b0;
    end else begin
      state      <= next_state;
      wb_sel     <= next_wb_sel;
      trap_cause <= next_cause;
      mem_req    <= (next_state == S_FETCH) || (next_state == S_MEM);
      if (state == S_DECODE) alu_op <= dec_op;
      if (retire) instret <= instret + CNT_W'(1);
      if ((next_state != state) && ((next_state == S_FETCH) || (next_state == S_MEM)))
        wait_cnt <= 8'd0;
      else if (mem_req && mem_ready)
        wait_cnt <= 8'd0;
      else if (mem_req)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed table-driven bench for multicycle_ctrl plus hand-written sequences
// for decode coverage, memory timeouts, reset mid-handshake and instret wrap.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          alu_zero, alu_lt, mem_ready;
  logic          mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write;
  logic [1:0]    wb_sel;
  logic [5:0]    alu_op;
  logic [2:0]    state;
  logic          halted;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel),
    .alu_op(alu_op), .state(state), .halted(halted), .trap_cause(trap_cause),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Instruction fields packed as {opcode, funct3, funct7}.
  localparam logic [16:0] I_ADD  = {7'b0110011, 3'b000, 7'b0000000};
  localparam logic [16:0] I_SUB  = {7'b0110011, 3'b000, 7'b0100000};
  localparam logic [16:0] I_LW   = {7'b0000011, 3'b010, 7'b0000000};
  localparam logic [16:0] I_SW   = {7'b0100011, 3'b010, 7'b0000000};
  localparam logic [16:0] I_BEQ  = {7'b1100011, 3'b000, 7'b0000000};
  localparam logic [16:0] I_BLT  = {7'b1100011, 3'b100, 7'b0000000};
  localparam logic [16:0] I_JAL  = {7'b1101111, 3'b000, 7'b0000000};
  localparam logic [16:0] I_ADDI = {7'b0010011, 3'b000, 7'b0000000};
  localparam logic [16:0] I_ILL  = {7'b1111111, 3'b000, 7'b0000000};

  // Strobe bundle {mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write}.
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] FET  = 7'b1001100;
  localparam logic [6:0] REQF = 7'b1000000;
  localparam logic [6:0] MEMR = 7'b1010000;
  localparam logic [6:0] MEMW = 7'b1110000;
  localparam logic [6:0] BRT  = 7'b0000110;
  localparam logic [6:0] BRN  = 7'b0000010;
  localparam logic [6:0] WBS  = 7'b0000001;

  typedef struct {
    logic        rst;
    logic [16:0] ins;
    logic        z, lt, rdy;
    logic [2:0]  st;
    logic [6:0]  stb;
    logic [1:0]  wbs;
    logic [5:0]  aop;
    logic        halt;
    logic [1:0]  cause;
    int          ir;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic r, input logic [16:0] ins, input logic z, input logic lt,
                        input logic rdy, input logic [2:0] st, input logic [6:0] stb,
                        input logic [1:0] wbs, input logic [5:0] aop, input logic halt,
                        input logic [1:0] cause, input int ir);
    vec_t v;
    v.rst = r; v.ins = ins; v.z = z; v.lt = lt; v.rdy = rdy; v.st = st; v.stb = stb;
    v.wbs = wbs; v.aop = aop; v.halt = halt; v.cause = cause; v.ir = ir;
    vecs.push_back(v);
  endtask

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setIns(input logic [16:0] ins);
    opcode = ins[16:10];
    funct3 = ins[9:7];
    funct7 = ins[6:0];
  endtask

  task automatic applyStimulus(input vec_t v);
    rst       = v.rst;
    alu_zero  = v.z;
    alu_lt    = v.lt;
    mem_ready = v.rdy;
    setIns(v.ins);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    expectEq($sformatf("state[%0d]", idx), 32'(state), 32'(v.st));
    expectEq($sformatf("strobes[%0d]", idx),
             32'({mem_req, mem_we, mem_sel, ir_write, pc_write, pc_src, reg_write}), 32'(v.stb));
    expectEq($sformatf("wb_sel[%0d]", idx), 32'(wb_sel), 32'(v.wbs));
    expectEq($sformatf("alu_op[%0d]", idx), 32'(alu_op), 32'(v.aop));
    expectEq($sformatf("halted[%0d]", idx), 32'(halted), 32'(v.halt));
    expectEq($sformatf("trap_cause[%0d]", idx), 32'(trap_cause), 32'(v.cause));
    expectEq($sformatf("instret[%0d]", idx), 32'(instret), 32'(v.ir));
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic runDecode(input logic [16:0] ins, input logic [5:0] exp_aop);
    mem_ready = 1'b1;
    setIns(ins);
    resetCycle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #1;
    expectEq($sformatf("dec_op %h", ins), 32'(alu_op), 32'(exp_aop));
    expectEq($sformatf("dec_state %h", ins), 32'(state), (exp_aop == 6'd0) ? 32'd5 : 32'd2);
  endtask

  // Brings a fresh lw up to its first MEM cycle with mem_ready low.
  task automatic lwToMem();
    mem_ready = 1'b1;
    setIns(I_LW);
    resetCycle();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; alu_zero = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
    setIns(I_ADD);
    @(negedge clk);
    @(negedge clk);
    #1;
    expectEq("rst_state", 32'(state), 32'd0);
    expectEq("rst_mem_req", 32'(mem_req), 32'd0);
    expectEq("rst_alu_op", 32'(alu_op), 32'd0);
    expectEq("rst_wb_sel", 32'(wb_sel), 32'd0);
    expectEq("rst_cause", 32'(trap_cause), 32'd0);
    expectEq("rst_instret", 32'(instret), 32'd0);
    @(negedge clk);

    //      rst ins    z  lt rdy st strobes wbs aop h c  ir
    addVec(0, I_ADD,  0, 0, 1,  0, NONE,  0, 0,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 1,  0, FET,   0, 0,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 1,  1, NONE,  0, 0,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 1,  2, NONE,  0, 1,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 1,  4, WBS,   0, 1,  0, 0, 0);
    addVec(0, I_LW,   0, 0, 1,  0, FET,   0, 1,  0, 0, 1);
    addVec(0, I_LW,   0, 0, 0,  1, NONE,  0, 1,  0, 0, 1);
    addVec(0, I_LW,   0, 0, 0,  2, NONE,  0, 12, 0, 0, 1);
    addVec(0, I_LW,   0, 0, 0,  3, MEMR,  0, 12, 0, 0, 1);
    addVec(0, I_LW,   0, 0, 0,  3, MEMR,  0, 12, 0, 0, 1);
    addVec(0, I_LW,   0, 0, 0,  3, MEMR,  0, 12, 0, 0, 1);
    addVec(0, I_LW,   0, 0, 1,  3, MEMR,  0, 12, 0, 0, 1);
    addVec(0, I_LW,   0, 0, 1,  4, WBS,   1, 12, 0, 0, 1);
    addVec(0, I_BEQ,  1, 0, 1,  0, FET,   1, 12, 0, 0, 2);
    addVec(0, I_BEQ,  1, 0, 1,  1, NONE,  1, 12, 0, 0, 2);
    addVec(0, I_BEQ,  1, 0, 1,  2, BRT,   1, 10, 0, 0, 2);
    addVec(0, I_BLT,  1, 0, 1,  0, FET,   1, 10, 0, 0, 3);
    addVec(0, I_BLT,  1, 0, 1,  1, NONE,  1, 10, 0, 0, 3);
    addVec(0, I_BLT,  1, 0, 1,  2, BRN,   1, 9,  0, 0, 3);
    addVec(0, I_JAL,  0, 0, 1,  0, FET,   1, 9,  0, 0, 4);
    addVec(0, I_JAL,  0, 0, 1,  1, NONE,  1, 9,  0, 0, 4);
    addVec(0, I_JAL,  0, 0, 1,  2, BRT,   1, 4,  0, 0, 4);
    addVec(0, I_JAL,  0, 0, 1,  4, WBS,   2, 4,  0, 0, 4);
    addVec(0, I_SW,   0, 0, 1,  0, FET,   2, 4,  0, 0, 5);
    addVec(0, I_SW,   0, 0, 1,  1, NONE,  2, 4,  0, 0, 5);
    addVec(0, I_SW,   0, 0, 1,  2, NONE,  2, 13, 0, 0, 5);
    addVec(0, I_SW,   0, 0, 1,  3, MEMW,  2, 13, 0, 0, 5);
    addVec(0, I_ADDI, 0, 0, 1,  0, FET,   2, 13, 0, 0, 6);
    addVec(0, I_ADDI, 0, 0, 1,  1, NONE,  2, 13, 0, 0, 6);
    addVec(0, I_ADDI, 0, 0, 1,  2, NONE,  2, 5,  0, 0, 6);
    addVec(0, I_ILL,  0, 0, 1,  4, WBS,   0, 5,  0, 0, 6);
    addVec(0, I_ILL,  0, 0, 1,  0, FET,   0, 5,  0, 0, 7);
    addVec(0, I_ILL,  0, 0, 1,  1, NONE,  0, 5,  0, 0, 7);
    addVec(0, I_ILL,  0, 0, 1,  5, NONE,  0, 0,  1, 1, 7);
    addVec(0, I_ILL,  0, 0, 1,  5, NONE,  0, 0,  1, 1, 7);
    addVec(1, I_ILL,  0, 0, 1,  5, NONE,  0, 0,  1, 1, 7);
    addVec(0, I_ADD,  0, 0, 0,  0, NONE,  0, 0,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 0,  0, REQF,  0, 0,  0, 0, 0);
    addVec(0, I_ADD,  0, 0, 1,  0, FET,   0, 0,  0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      @(negedge clk);
    end

    runDecode(I_ADD, 6'd1);
    runDecode(I_SUB, 6'd2);
    runDecode({7'b0110011, 3'b001, 7'b0000000}, 6'd3);
    runDecode({7'b0110011, 3'b111, 7'b0000000}, 6'd6);
    runDecode({7'b0110011, 3'b110, 7'b0000000}, 6'd7);
    runDecode({7'b0110011, 3'b100, 7'b0000000}, 6'd8);
    runDecode({7'b0110011, 3'b101, 7'b0000000}, 6'd11);
    runDecode({7'b0110011, 3'b001, 7'b0100000}, 6'd0);
    runDecode({7'b0010011, 3'b001, 7'b0000000}, 6'd0);
    runDecode({7'b0000011, 3'b000, 7'b0000000}, 6'd0);
    runDecode({7'b0100011, 3'b001, 7'b0000000}, 6'd0);
    runDecode({7'b1100011, 3'b001, 7'b0000000}, 6'd0);

    // Fetch timeout: four wait cycles with mem_req high, then TRAP cause 2.
    mem_ready = 1'b0;
    setIns(I_ADD);
    resetCycle();
    @(negedge clk);
    for (int k = 0; k < TO; k++) begin
      #1;
      expectEq($sformatf("fto_req%0d", k), 32'(mem_req), 32'd1);
      expectEq($sformatf("fto_state%0d", k), 32'(state), 32'd0);
      @(negedge clk);
    end
    #1;
    expectEq("fto_state", 32'(state), 32'd5);
    expectEq("fto_cause", 32'(trap_cause), 32'd2);
    expectEq("fto_req_off", 32'(mem_req), 32'd0);
    expectEq("fto_halted", 32'(halted), 32'd1);

    // Memory timeout on a lw.
    lwToMem();
    for (int k = 0; k < TO; k++) begin
      #1;
      expectEq($sformatf("mto_req%0d", k), 32'({mem_req, mem_sel, mem_we}), 32'b110);
      @(negedge clk);
    end
    #1;
    expectEq("mto_state", 32'(state), 32'd5);
    expectEq("mto_cause", 32'(trap_cause), 32'd3);
    expectEq("mto_req_off", 32'(mem_req), 32'd0);

    // Reset in the middle of a MEM wait.
    lwToMem();
    #1;
    expectEq("mrst_pre_state", 32'(state), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    expectEq("mrst_state", 32'(state), 32'd0);
    expectEq("mrst_req", 32'(mem_req), 32'd0);

    // instret wraps at 2^CW with back-to-back not-taken branches.
    mem_ready = 1'b1;
    alu_zero = 1'b0;
    setIns(I_BEQ);
    resetCycle();
    @(negedge clk);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      expectEq($sformatf("wrap_instret%0d", n), 32'(instret), 32'(n % 16));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
